// File: rtl/restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, DW-bit dividend by VW-bit divisor.
// Optional DIV_ZERO_FLAG_EN macro adds the div_by_zero output.
module restoring_divider #(
  parameter int DW = 10,
  parameter int VW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic          div_by_zero
`endif
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [VW:0]   rem_acc;
  logic [DW-1:0] quo_acc;
  logic [VW-1:0] dvs;
  logic          dz_flag;
  logic [VW+DW:0] step_res;

  // One restoring step: shift in the next dividend bit, trial-subtract,
  // keep the difference only when it did not borrow.
  function automatic logic [VW+DW:0] div_step(
    input logic [VW:0]   r,
    input logic [DW-1:0] q,
    input logic [VW-1:0] d
  );
    logic [VW:0]   rs;
    logic [VW+1:0] t;
    rs = {r[VW-1:0], q[DW-1]};
    t  = {1'b0, rs} - {2'b00, d};
    if (!t[VW+1])
      div_step = {t[VW:0], q[DW-2:0], 1'b1};
    else
      div_step = {rs, q[DW-2:0], 1'b0};
  endfunction

  always_comb begin
    step_res = div_step(rem_acc, quo_acc, dvs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      count     <= '0;
      rem_acc   <= '0;
      quo_acc   <= '0;
      dvs       <= '0;
      dz_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvs      <= divisor;
            quo_acc  <= dividend;
            rem_acc  <= '0;
            count    <= CW'(DW);
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              dz_flag   <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_acc <= step_res[VW+DW:DW];
          quo_acc <= step_res[DW-1:0];
          count   <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= step_res[DW-1:0];
            remainder <= step_res[VW+DW-1:DW];
          end
        end
        DONE: begin
          // Result registers hold until the consumer takes them.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            dz_flag   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  assign div_by_zero = dz_flag;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus a random sweep
// checked against plain integer division.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] dividend;
  logic [4:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] quotient;
  logic [4:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic       div_by_zero;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  restoring_divider #(.DW(10), .VW(5)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  // Present an operand pair and hold it until the accepting edge has passed.
  task automatic send(input logic [9:0] a, input logic [4:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 50);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, quotient, remainder} !== {1'b1, 1'b0, 10'd0, 5'd0}) begin
      fails++;
      $display("FAIL reset_state in_ready=%0b out_valid=%0b q=%0d r=%0d required 1 0 0 0",
               in_ready, out_valid, quotient, remainder);
    end
  endtask

  task automatic test_divide(input logic [9:0] a, input logic [4:0] b,
                             input int exp_lat, input string name);
    int cyc;
    int eq, er;
    eq = (b == 0) ? 1023 : int'(a) / int'(b);
    er = (b == 0) ? 0 : int'(a) % int'(b);
    send(a, b);
    wait_result(cyc);
    tests++;
    if (cyc !== exp_lat || !out_valid) begin
      fails++;
      $display("FAIL %s_latency got %0d cycles (out_valid=%0b) required %0d", name, cyc, out_valid, exp_lat);
    end
    tests++;
    if (quotient !== 10'(eq) || remainder !== 5'(er)) begin
      fails++;
      $display("FAIL %s_value q=%0d r=%0d required q=%0d r=%0d", name, quotient, remainder, eq, er);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_in_ready_done got %0b required 0", name, in_ready);
    end
`ifdef DIV_ZERO_FLAG_EN
    tests++;
    if (div_by_zero !== (b == 0)) begin
      fails++;
      $display("FAIL %s_div_by_zero got %0b required %0b", name, div_by_zero, (b == 0));
    end
`endif
    consume();
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    send(10'd0, 5'd5);
    wait_result(cyc);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (!out_valid || quotient !== 10'd0 || remainder !== 5'd0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold cycle %0d ov=%0b q=%0d r=%0d ir=%0b required 1 0 0 0",
                 i, out_valid, quotient, remainder, in_ready);
      end
      @(posedge clk); #1;
    end
    consume();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release ov=%0b ir=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_busy();
    send(10'd1000, 5'd7);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy ir=%0b ov=%0b required 1 0", in_ready, out_valid);
    end
    repeat (12) begin
      @(posedge clk); #1;
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_stale ov=%0b required 0", out_valid);
    end
    test_divide(10'd341, 5'd17, 10, "after_reset_341_17");
  endtask

  task automatic test_back_to_back();
    int cyc;
    send(10'd900, 5'd13);
    // Next pair is offered immediately and must wait for the first result to drain.
    in_valid = 1'b1;
    dividend = 10'd777;
    divisor  = 5'd9;
    wait_result(cyc);
    tests++;
    if (cyc !== 10 || quotient !== 10'd69 || remainder !== 5'd3) begin
      fails++;
      $display("FAIL b2b_first cyc=%0d q=%0d r=%0d required 10 69 3", cyc, quotient, remainder);
    end
    consume();
    test_divide(10'd777, 5'd9, 10, "b2b_second");
  endtask

  task automatic test_random_sweep();
    int cyc;
    logic [9:0] a;
    logic [4:0] b;
    for (int i = 0; i < 2000; i++) begin
      a = 10'($urandom_range(0, 1023));
      b = 5'($urandom_range(1, 31));
      send(a, b);
      wait_result(cyc);
      tests++;
      if (!out_valid || int'(quotient) * int'(b) + int'(remainder) != int'(a) ||
          remainder >= b || quotient !== 10'(int'(a) / int'(b))) begin
        fails++;
        $display("FAIL random_%0d %0d/%0d got q=%0d r=%0d ov=%0b required q=%0d r=%0d",
                 i, a, b, quotient, remainder, out_valid, int'(a) / int'(b), int'(a) % int'(b));
      end
      consume();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_divide(10'b0000111100, 5'd3, 10, "div_60_3");
    test_divide(10'd1023, 5'd31, 10, "div_1023_31");
    test_divide(10'd1000, 5'd7, 10, "div_1000_7");
    test_divide(10'd5, 5'd0, 1, "div_5_0");
    test_divide(10'd1023, 5'd1, 10, "div_1023_1");
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
